ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Instruction fetch front-end: issues word fetches to a variable-latency instruction memory
//  and buffers {pc4, order} pairs in a DEPTH-entry queue that feeds the IF/ID pipe register.
//  Decouples the pipeline from memory latency; honours hazard stall and branch/jump redirect.
// PARAMETERS
//  DEPTH     4              queue entries; power of two, >=2
//  RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-low reset (rst==0 resets on next clk edge)
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  fetch word address; stable while imem_req high
//  imem_ack     in   1   response strobe; one cycle, with imem_rdata
//  imem_rdata   in   32  fetched instruction, valid with imem_ack
//  redirect     in   1   flush queue and restart at redirect_pc (branch taken / jump)
//  redirect_pc  in   32  new fetch address, word aligned
//  stall        in   1   hazard: consumer does not take the head entry this cycle
//  out_valid    out  1   head entry valid
//  out_order    out  32  head instruction; 32'h0 (NOP) when !out_valid
//  out_pc4      out  32  address of head instruction + 4; 0 when !out_valid
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, count=0, rd/wr ptr=0, state=RUN, imem_req=0, out_valid=0,
//    out_order=0, out_pc4=0. Reset mid-request abandons it; late ack after reset is ignored
//    only if it arrives while rst==0.
//  - Pop: out_valid && !stall at edge -> head removed. Push: imem_ack in state WAIT -> {fetch_pc+4, rdata}
//    written at tail, fetch_pc+=4 (mod 2^32; 0xFFFF_FFFC wraps to 0). Push+pop same cycle: count unchanged.
//  - At most one request outstanding. Issue when state==RUN and count+pop-adjusted < DEPTH:
//    imem_req=1, imem_addr=fetch_pc, state->WAIT. Full: no request issued.
//  - Latency: ack in cycle t -> entry visible on out_* in t+1 (registered queue).
//  - FSM: RUN --issue--> WAIT --ack--> RUN (may re-issue next cycle);
//    WAIT --redirect w/o ack--> DRAIN (req held on old addr) --ack, data dropped--> RUN.
//  - Redirect (highest priority, beats push/pop/stall): count=0, ptrs=0, fetch_pc=redirect_pc,
//    out_valid=0 next cycle; an ack in the redirect cycle is discarded; state RUN or DRAIN as above.
//    Redirect in DRAIN: update fetch_pc, stay DRAIN.
//  - Empty: out_valid=0, out_order=0, stall ignored. Pointers wrap mod DEPTH.
// CONFIGURATION
//  IFETCH_QUEUE_BYPASS_EN defined: when queue empty, state WAIT, imem_ack=1 and !redirect, out_*
//    driven combinationally from {fetch_pc+4, imem_rdata} with out_valid=1 (latency 0); if !stall
//    entry consumed and not written, else written to queue.
//  Not defined: pure registered path, latency 1 as above; no combinational imem->out path.
// STRUCTURE
//  - Shared package ifq_pkg: state encoding (RUN/WAIT/DRAIN), entry typedef {pc4[31:0], order[31:0]},
//    NOP constant 32'h0, WORD_STEP=4.
//  - Sub-module ifq_fifo: DEPTH x 64 storage, wr/rd ptrs, count, push/pop/flush; top holds FSM + fetch_pc.
// TESTING
//  1 Reset, imem acks after 2 cycles, stall=0 -> addrs 0,4,8.. requested; out_pc4=4,8,12 in order,
//    out_valid 1 cycle after each ack (bypass off).
//  2 stall=1 held, DEPTH=4 -> exactly 4 entries pushed, imem_req stays 0 when full; release stall
//    -> pops 4 entries in order, fetching resumes.
//  3 Redirect to 0x40 while WAIT on 0x08, ack 3 cycles later -> DRAIN, 0x08 data dropped,
//    next imem_addr=0x40, first out_pc4=0x44.
//  4 Redirect coincident with ack and pop -> queue empty next cycle, acked data discarded, out_valid=0.
//  5 redirect_pc=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000; out_pc4=0x0 then 0x4.
//  6 IFETCH_QUEUE_BYPASS_EN, empty queue, ack with rdata=0x2002_0005 -> out_valid=1, out_order=0x2002_0005
//    same cycle; with stall=1 entry appears registered next cycle, count=1.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue.
//   ifq_state_e  - fetch FSM state (RUN / WAIT / DRAIN)
//   ifq_entry_t  - queue entry {pc4, order}
//   NOP          - instruction presented when no entry is valid
//   WORD_STEP    - fetch address increment per instruction word
package ifq_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_DRAIN
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] order;
  } ifq_entry_t;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] WORD_STEP = 32'd4;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of fetch entries.
//   clk, rst   - clock, synchronous active-low reset
//   flush      - empty the buffer (wins over push/pop)
//   push       - write wr_entry at the tail
//   pop        - drop the head entry
//   wr_entry   - entry to write
//   rd_entry   - current head entry (registered storage, read combinationally)
//   count      - number of valid entries
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  ifq_entry_t               wr_entry,
  output ifq_entry_t               rd_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ifq_entry_t     mem_q [DEPTH];
  ifq_entry_t     mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two DEPTH: pointer overflow is the modulo wrap.
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front-end. Issues one word fetch at a time
// to a variable-latency instruction memory and buffers {pc4, order} entries
// in a DEPTH-entry queue feeding the IF/ID register.
//   clk, rst              - clock, synchronous active-low reset
//   imem_req, imem_addr   - fetch request / word address, held until imem_ack
//   imem_ack, imem_rdata  - one-cycle response strobe with instruction
//   redirect, redirect_pc - flush and restart fetching at redirect_pc
//   stall                 - consumer does not take the head entry this cycle
//   out_valid, out_order, out_pc4 - head entry (NOP / 0 when not valid)
// Build option: IFETCH_QUEUE_BYPASS_EN adds a zero-latency path from the
// memory response to out_* while the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_order,
  output logic [31:0] out_pc4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifq_state_e    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;

  logic [CW-1:0] count;
  logic [CW-1:0] occ_after_pop;
  ifq_entry_t    head, new_entry;
  logic          q_valid, bypass_hit, pop, push, flush, issue;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .wr_entry (new_entry),
    .rd_entry (head),
    .count    (count)
  );

  always_comb begin
    q_valid   = (count != '0);
    new_entry = '{pc4: fetch_pc_q + WORD_STEP, order: imem_rdata};

`ifdef IFETCH_QUEUE_BYPASS_EN
    bypass_hit = !q_valid && (state_q == ST_WAIT) && imem_ack && !redirect;
`else
    bypass_hit = 1'b0;
`endif

    out_valid = q_valid || bypass_hit;
    out_order = NOP;
    out_pc4   = '0;
    if (q_valid) begin
      out_order = head.order;
      out_pc4   = head.pc4;
    end else if (bypass_hit) begin
      out_order = new_entry.order;
      out_pc4   = new_entry.pc4;
    end

    flush = redirect;
    pop   = q_valid && !stall && !redirect;
    // A bypassed response taken by the consumer never enters the queue.
    push  = (state_q == ST_WAIT) && imem_ack && !redirect && !(bypass_hit && !stall);

    occ_after_pop = count - CW'(pop);
    issue         = (state_q == ST_RUN) && !redirect && (occ_after_pop < CW'(DEPTH));

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // An outstanding request still owes an ack; its data must be dropped.
      state_d    = ((state_q != ST_RUN) && !imem_ack) ? ST_DRAIN : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (issue) begin
            state_d    = ST_WAIT;
            req_addr_d = fetch_pc_q;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + WORD_STEP;
            state_d    = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Request address is captured at issue so it stays put through DRAIN
  // even though fetch_pc already holds the redirect target.
  assign imem_req  = (state_q != ST_RUN);
  assign imem_addr = req_addr_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized and directed stimulus for ifetch_queue, checked
// every cycle against a queue-based behavioural model of the fetch front-end.
module tb_ifetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, redirect, stall, out_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_order, out_pc4;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .out_valid(out_valid),
    .out_order(out_order), .out_pc4(out_pc4)
  );

  // Model: queue contents, next fetch address, outstanding-request flags.
  logic [63:0] mq[$];
  logic [31:0] m_fpc, m_raddr;
  bit          m_pend, m_drop;
  // Memory responder.
  bit          mem_txn;
  int          mem_cnt;
  // Knobs.
  int          k_lat, k_stall_pct, k_redir_pct;
  int          trig_mode;
  logic [31:0] trig_addr, trig_pc;
  bit          trig_hit;
  bit          fix_rdata_en;
  logic [31:0] fix_rdata;
  bit          probe_hit;
  logic [31:0] probe_valid, probe_order;
  // Logs.
  logic [31:0] addr_log[$], pop_log[$];
  int          ack_cnt;
  int          total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fpc = 32'h0; m_raddr = 32'h0; m_pend = 0; m_drop = 0;
    mem_txn = 0; mem_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    model_reset();
    addr_log.delete(); pop_log.delete(); ack_cnt = 0;
    trig_mode = 0; trig_hit = 0; fix_rdata_en = 0; probe_hit = 0;
    k_redir_pct = 0;
  endtask

  task automatic step(input bit do_rst);
    bit          rd, st, ack, byp, mv;
    logic [31:0] rpc, rdata, mo, mp;
    ack   = 0;
    rdata = fix_rdata_en ? fix_rdata : $urandom;
    if (!do_rst && m_pend) begin
      if (!mem_txn) begin
        mem_txn = 1;
        mem_cnt = (k_lat < 0) ? int'($urandom_range(0, 3)) : k_lat;
        addr_log.push_back(m_raddr);
      end
      if (mem_cnt == 0) ack = 1;
      else mem_cnt--;
    end
    st  = (int'($urandom_range(0, 99)) < k_stall_pct);
    rd  = (trig_mode == 1) && (int'($urandom_range(0, 99)) < k_redir_pct);
    rpc = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4
                                      : 32'($urandom_range(0, 63)) * 4;
    if (trig_mode == 2 && !trig_hit && m_pend && m_raddr == trig_addr && !ack) begin
      rd = 1; rpc = trig_pc; trig_hit = 1;
    end
    if (trig_mode == 3 && !trig_hit && ack && mq.size() > 0 && !st) begin
      rd = 1; rpc = trig_pc; trig_hit = 1;
    end
    rst = !do_rst; redirect = rd; redirect_pc = rpc; stall = st;
    imem_ack = ack; imem_rdata = rdata;
    #1;
    mv = 0; mo = 32'h0; mp = 32'h0;
    if (mq.size() > 0) begin
      mv = 1; mp = mq[0][63:32]; mo = mq[0][31:0];
    end
`ifdef IFETCH_QUEUE_BYPASS_EN
    else if (m_pend && !m_drop && ack && !rd) begin
      mv = 1; mp = m_fpc + 32'd4; mo = rdata;
    end
`endif
    check("imem_req", 32'(imem_req), 32'(m_pend));
    if (m_pend) check("imem_addr", imem_addr, m_raddr);
    check("out_valid", 32'(out_valid), 32'(mv));
    check("out_order", out_order, mo);
    check("out_pc4", out_pc4, mp);
    if (ack && !probe_hit) begin
      probe_hit = 1; probe_valid = 32'(out_valid); probe_order = out_order;
    end
    if (do_rst) begin
      model_reset();
    end else if (rd) begin
      mq.delete();
      m_fpc = rpc;
      if (m_pend && !ack) m_drop = 1;
      else begin m_pend = 0; m_drop = 0; end
      if (ack) mem_txn = 0;
    end else begin
      byp = 0;
      if (mv && !st) begin
        pop_log.push_back(mp);
        if (mq.size() > 0) void'(mq.pop_front());
        else byp = 1;
      end
      if (m_pend && ack) begin
        if (!m_drop) begin
          if (!byp) mq.push_back({m_fpc + 32'd4, rdata});
          ack_cnt++;
          m_fpc = m_fpc + 32'd4;
        end
        m_pend = 0; m_drop = 0; mem_txn = 0;
      end else if (!m_pend && mq.size() < DEPTH) begin
        m_pend = 1; m_raddr = m_fpc;
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    k_lat = 2; k_stall_pct = 0;
    do_reset();
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_order", out_order, 32'h0);
    check("rst_pc4", out_pc4, 32'h0);

    // Sequential fetch, fixed latency 2, no stall.
    for (int i = 0; i < 30; i++) step(0);
    check("seq_addr0", qat(addr_log, 0), 32'h0);
    check("seq_addr1", qat(addr_log, 1), 32'h4);
    check("seq_addr2", qat(addr_log, 2), 32'h8);
    check("seq_pop0", qat(pop_log, 0), 32'h4);
    check("seq_pop1", qat(pop_log, 1), 32'h8);
    check("seq_pop2", qat(pop_log, 2), 32'hC);

    // Stall held until full, then drain.
    do_reset();
    k_lat = 1; k_stall_pct = 100;
    for (int i = 0; i < 40; i++) step(0);
    check("full_acks", 32'(ack_cnt), 32'd4);
    check("full_req", 32'(imem_req), 32'h0);
    check("full_head", out_pc4, 32'h4);
    k_stall_pct = 0;
    for (int i = 0; i < 30; i++) step(0);
    check("drain_pop0", qat(pop_log, 0), 32'h4);
    check("drain_pop1", qat(pop_log, 1), 32'h8);
    check("drain_pop2", qat(pop_log, 2), 32'hC);
    check("drain_pop3", qat(pop_log, 3), 32'h10);
    check("resume_addr", qat(addr_log, 4), 32'h10);

    // Redirect while waiting on 0x08.
    do_reset();
    k_lat = 3; k_stall_pct = 0;
    trig_mode = 2; trig_addr = 32'h8; trig_pc = 32'h40;
    for (int i = 0; i < 40; i++) step(0);
    check("drain_hit", 32'(trig_hit), 32'h1);
    check("drain_next_addr", qat(addr_log, 3), 32'h40);
    check("drain_first_pop", qat(pop_log, 2), 32'h44);

    // Redirect coincident with ack and pop.
    do_reset();
    k_lat = 0; k_stall_pct = 50;
    trig_mode = 3; trig_pc = 32'h100;
    for (int i = 0; i < 300 && !trig_hit; i++) step(0);
    check("coinc_hit", 32'(trig_hit), 32'h1);
    if (trig_hit) begin
      check("coinc_valid", 32'(out_valid), 32'h0);
      check("coinc_req", 32'(imem_req), 32'h0);
    end
    for (int i = 0; i < 20; i++) step(0);

    // Address wrap at the top of memory.
    do_reset();
    k_lat = 1; k_stall_pct = 0;
    trig_mode = 2; trig_addr = 32'h0; trig_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 30; i++) step(0);
    check("wrap_addr1", qat(addr_log, 1), 32'hFFFF_FFFC);
    check("wrap_addr2", qat(addr_log, 2), 32'h0);
    check("wrap_pop0", qat(pop_log, 0), 32'h0);
    check("wrap_pop1", qat(pop_log, 1), 32'h4);

`ifdef IFETCH_QUEUE_BYPASS_EN
    // Zero-latency path on an empty queue, stalled consumer.
    do_reset();
    k_lat = 2; k_stall_pct = 100;
    fix_rdata_en = 1; fix_rdata = 32'h2002_0005;
    for (int i = 0; i < 20 && !probe_hit; i++) step(0);
    check("byp_hit", 32'(probe_hit), 32'h1);
    check("byp_valid", probe_valid, 32'h1);
    check("byp_order", probe_order, 32'h2002_0005);
    check("byp_reg_valid", 32'(out_valid), 32'h1);
    check("byp_reg_order", out_order, 32'h2002_0005);
    fix_rdata_en = 0;
`endif

    // Random traffic with redirects and occasional reset.
    do_reset();
    k_lat = -1; k_stall_pct = 30; k_redir_pct = 4; trig_mode = 1;
    for (int i = 0; i < 3000; i++) step(int'($urandom_range(0, 99)) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
